// File: rtl/control_operandos.sv
// rtl/control_operandos.sv - keypad sequencer for the BCD calculator operands
// Optional feature macro: CTRL_TIMEOUT_EN (adder watchdog, TIMEOUT_CICLOS cycles)
module control_operandos #(
    parameter int N_DIGITOS      = 4,
    parameter int TIMEOUT_CICLOS = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tecla_valida,
    input  logic [3:0]             tecla,
    input  logic                   suma_listo,
    output logic [4*N_DIGITOS-1:0] numero_ent,
    output logic [2:0]             n_dig,
    output logic [4*N_DIGITOS-1:0] operando_a,
    output logic [4*N_DIGITOS-1:0] operando_b,
    output logic                   inicio_suma,
    output logic                   mostrar_resultado,
    output logic [1:0]             estado,
    output logic                   error
);

    localparam int         W     = 4 * N_DIGITOS;
    localparam logic [2:0] N_MAX = 3'(N_DIGITOS);

    typedef enum logic [1:0] {
        ENTRADA_A = 2'd0,
        ENTRADA_B = 2'd1,
        SUMANDO   = 2'd2,
        MOSTRAR   = 2'd3
    } estado_t;

    estado_t st, st_next;

    logic key_digito;
    logic key_guardar;
    logic key_borrar;
    logic key_cancelar;
    logic en_entrada;
    logic hay_espacio;
    logic expira;

    // Key decode; codes 0xD-0xF match nothing and therefore do nothing
    assign key_digito   = tecla_valida && (tecla <= 4'd9);
    assign key_guardar  = tecla_valida && (tecla == 4'hA);
    assign key_borrar   = tecla_valida && (tecla == 4'hB);
    assign key_cancelar = tecla_valida && (tecla == 4'hC);
    assign en_entrada   = (st == ENTRADA_A) || (st == ENTRADA_B);
    assign hay_espacio  = (n_dig < N_MAX);

`ifdef CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
    logic [CW-1:0] cuenta;

    // Watchdog counter: 0 on the first SUMANDO cycle, counts while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta <= '0;
        end else if (st != SUMANDO) begin
            cuenta <= '0;
        end else begin
            cuenta <= cuenta + CW'(1);
        end
    end

    // Expiry fires on the edge closing the TIMEOUT_CICLOS-th SUMANDO cycle
    assign expira = (st == SUMANDO) && (cuenta == CW'(TIMEOUT_CICLOS - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CICLOS > 0);
    assign expira         = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= ENTRADA_A;
        end else begin
            st <= st_next;
        end
    end

    // Next-state logic; cancelar overrides everything, suma_listo beats expiry
    always_comb begin
        st_next = st;
        if (key_cancelar) begin
            st_next = ENTRADA_A;
        end else begin
            case (st)
                ENTRADA_A: if (key_guardar) st_next = ENTRADA_B;
                ENTRADA_B: if (key_guardar) st_next = SUMANDO;
                SUMANDO: begin
                    if (suma_listo) begin
                        st_next = MOSTRAR;
                    end else if (expira) begin
                        st_next = ENTRADA_A;
                    end
                end
                MOSTRAR:   if (key_digito) st_next = ENTRADA_A;
                default:   st_next = ENTRADA_A;
            endcase
        end
    end

    // State-derived outputs, taken straight from the state register
    always_comb begin
        estado            = st;
        mostrar_resultado = (st == MOSTRAR);
    end

    // Entry, operand, start pulse and error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            numero_ent  <= '0;
            n_dig       <= '0;
            operando_a  <= '0;
            operando_b  <= '0;
            inicio_suma <= 1'b0;
            error       <= 1'b0;
        end else begin
            inicio_suma <= 1'b0;
            if (key_cancelar) begin
                numero_ent <= '0;
                n_dig      <= '0;
                operando_a <= '0;
                operando_b <= '0;
                error      <= 1'b0;
            end else if (en_entrada) begin
                if (key_digito && hay_espacio) begin
                    numero_ent <= {numero_ent[W-5:0], tecla};
                    n_dig      <= n_dig + 3'd1;
                    error      <= 1'b0;
                end else if (key_borrar) begin
                    numero_ent <= '0;
                    n_dig      <= '0;
                end else if (key_guardar) begin
                    if (st == ENTRADA_A) begin
                        operando_a <= numero_ent;
                    end else begin
                        operando_b  <= numero_ent;
                        // Only the ENTRADA_B->SUMANDO step ever raises the start pulse
                        inicio_suma <= 1'b1;
                    end
                    numero_ent <= '0;
                    n_dig      <= '0;
                end
            end else if (st == SUMANDO) begin
                if (!suma_listo && expira) begin
                    operando_a <= '0;
                    operando_b <= '0;
                    error      <= 1'b1;
                end
            end else begin
                // MOSTRAR: a digit starts a fresh calculation with that digit
                if (key_digito) begin
                    operando_a <= '0;
                    operando_b <= '0;
                    numero_ent <= {{(W-4){1'b0}}, tecla};
                    n_dig      <= 3'd1;
                    error      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_control_operandos.sv
// tb/tb_control_operandos.sv - self-checking bench for control_operandos
module tb_control_operandos;

    logic        clk;
    logic        rst_n;
    logic        tecla_valida;
    logic [3:0]  tecla;
    logic        suma_listo;
    logic [15:0] numero_ent;
    logic [2:0]  n_dig;
    logic [15:0] operando_a;
    logic [15:0] operando_b;
    logic        inicio_suma;
    logic        mostrar_resultado;
    logic [1:0]  estado;
    logic        error;

    int checks;
    int failures;

    control_operandos #(
        .N_DIGITOS      (4),
        .TIMEOUT_CICLOS (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .tecla_valida      (tecla_valida),
        .tecla             (tecla),
        .suma_listo        (suma_listo),
        .numero_ent        (numero_ent),
        .n_dig             (n_dig),
        .operando_a        (operando_a),
        .operando_b        (operando_b),
        .inicio_suma       (inicio_suma),
        .mostrar_resultado (mostrar_resultado),
        .estado            (estado),
        .error             (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  k;
        logic        sl;
        logic [15:0] ent;
        logic [2:0]  nd;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  st;
        logic        ini;
        logic        mos;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(input logic v, input logic [3:0] k, input logic sl,
                                input logic [15:0] ent, input logic [2:0] nd,
                                input logic [15:0] a, input logic [15:0] b,
                                input logic [1:0] st, input logic ini, input logic mos);
        vec_t r;
        r.v = v; r.k = k; r.sl = sl; r.ent = ent; r.nd = nd;
        r.a = a; r.b = b; r.st = st; r.ini = ini; r.mos = mos;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        tecla_valida = 1'b1;
        tecla        = k;
        @(negedge clk);
        tecla_valida = 1'b0;
    endtask

    task automatic tick(input logic sl);
        tecla_valida = 1'b0;
        suma_listo   = sl;
        @(negedge clk);
        suma_listo   = 1'b0;
    endtask

    initial begin
        vec_t e;
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        tecla_valida = 1'b0;
        tecla        = 4'h0;
        suma_listo   = 1'b0;

        //    v  key  sl  ent       nd  a         b         st  ini mos
        tbl.push_back(mk(1, 4'h1, 0, 16'h0001, 1, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h2, 0, 16'h0012, 2, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 0, 16'h0123, 3, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h4, 0, 16'h1234, 4, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hA, 0, 16'h0000, 0, 16'h1234, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(1, 4'h5, 0, 16'h0005, 1, 16'h1234, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(1, 4'h6, 0, 16'h0056, 2, 16'h1234, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(1, 4'h7, 0, 16'h0567, 3, 16'h1234, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(1, 4'h8, 0, 16'h5678, 4, 16'h1234, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(1, 4'h9, 0, 16'h5678, 4, 16'h1234, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(1, 4'hA, 0, 16'h0000, 0, 16'h1234, 16'h5678, 2, 1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 16'h1234, 16'h5678, 2, 0, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 16'h1234, 16'h5678, 2, 0, 0));
        tbl.push_back(mk(0, 4'h0, 1, 16'h0000, 0, 16'h1234, 16'h5678, 3, 0, 1));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 16'h1234, 16'h5678, 3, 0, 1));
        tbl.push_back(mk(1, 4'hA, 0, 16'h0000, 0, 16'h1234, 16'h5678, 3, 0, 1));
        tbl.push_back(mk(1, 4'hB, 0, 16'h0000, 0, 16'h1234, 16'h5678, 3, 0, 1));
        tbl.push_back(mk(1, 4'h7, 0, 16'h0007, 1, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h4, 0, 16'h0074, 2, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hB, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h9, 0, 16'h0009, 1, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hE, 0, 16'h0009, 1, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hD, 0, 16'h0009, 1, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hF, 0, 16'h0009, 1, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hB, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hA, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(1, 4'hA, 0, 16'h0000, 0, 16'h0000, 16'h0000, 2, 1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 2, 0, 0));
        tbl.push_back(mk(1, 4'h5, 0, 16'h0000, 0, 16'h0000, 16'h0000, 2, 0, 0));
        tbl.push_back(mk(1, 4'hA, 0, 16'h0000, 0, 16'h0000, 16'h0000, 2, 0, 0));
        tbl.push_back(mk(1, 4'hC, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h1, 0, 16'h0001, 1, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hA, 0, 16'h0000, 0, 16'h0001, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(1, 4'h2, 0, 16'h0002, 1, 16'h0001, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(1, 4'hA, 0, 16'h0000, 0, 16'h0001, 16'h0002, 2, 1, 0));
        tbl.push_back(mk(0, 4'h0, 0, 16'h0000, 0, 16'h0001, 16'h0002, 2, 0, 0));
        tbl.push_back(mk(1, 4'hC, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 0, 16'h0003, 1, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'hA, 0, 16'h0000, 0, 16'h0003, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(1, 4'hA, 0, 16'h0000, 0, 16'h0003, 16'h0000, 2, 1, 0));
        tbl.push_back(mk(0, 4'h0, 1, 16'h0000, 0, 16'h0003, 16'h0000, 3, 0, 1));
        tbl.push_back(mk(1, 4'hC, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0));

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst.ent", numero_ent, 16'h0);
        chk("rst.nd", n_dig, 3'd0);
        chk("rst.a", operando_a, 16'h0);
        chk("rst.b", operando_b, 16'h0);
        chk("rst.st", estado, 2'd0);
        chk("rst.ini", inicio_suma, 1'b0);
        chk("rst.mos", mostrar_resultado, 1'b0);
        chk("rst.err", error, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors through the scoreboard: push on drive, pop on result
        for (int i = 0; i < tbl.size(); i++) begin
            tecla_valida = tbl[i].v;
            tecla        = tbl[i].k;
            suma_listo   = tbl[i].sl;
            sb.push_back(tbl[i]);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("v%0d.ent", i), numero_ent, e.ent);
            chk($sformatf("v%0d.nd", i), n_dig, e.nd);
            chk($sformatf("v%0d.a", i), operando_a, e.a);
            chk($sformatf("v%0d.b", i), operando_b, e.b);
            chk($sformatf("v%0d.st", i), estado, e.st);
            chk($sformatf("v%0d.ini", i), inicio_suma, e.ini);
            chk($sformatf("v%0d.mos", i), mostrar_resultado, e.mos);
            chk($sformatf("v%0d.err", i), error, 1'b0);
        end
        tecla_valida = 1'b0;
        suma_listo   = 1'b0;
        chk("sb.empty", sb.size(), 0);

        // Asynchronous reset between edges, mid-entry
        press(4'h1);
        press(4'h2);
        chk("pre_rst.ent", numero_ent, 16'h0012);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.ent", numero_ent, 16'h0);
        chk("async_rst.nd", n_dig, 3'd0);
        chk("async_rst.st", estado, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        press(4'h6);
        chk("post_rst.ent", numero_ent, 16'h0006);
        chk("post_rst.nd", n_dig, 3'd1);

        // Reach SUMANDO with non-zero operands
        press(4'hA);
        press(4'h2);
        press(4'hA);
        chk("sum.st", estado, 2'd2);
        chk("sum.ini", inicio_suma, 1'b1);
`ifdef CTRL_TIMEOUT_EN
        for (int i = 0; i < 7; i++) tick(1'b0);
        chk("tmo.wait.st", estado, 2'd2);
        chk("tmo.wait.err", error, 1'b0);
        tick(1'b0);
        chk("tmo.st", estado, 2'd0);
        chk("tmo.err", error, 1'b1);
        chk("tmo.a", operando_a, 16'h0);
        chk("tmo.b", operando_b, 16'h0);
        press(4'h3);
        chk("tmo.clr.err", error, 1'b0);
        chk("tmo.clr.ent", numero_ent, 16'h0003);
        press(4'hB);
        press(4'hA);
        press(4'hA);
        chk("tmo2.st", estado, 2'd2);
        for (int i = 0; i < 7; i++) tick(1'b0);
        tick(1'b1);
        chk("tmo2.st_after", estado, 2'd3);
        chk("tmo2.err", error, 1'b0);
        chk("tmo2.mos", mostrar_resultado, 1'b1);
`else
        for (int i = 0; i < 20; i++) tick(1'b0);
        chk("wait.st", estado, 2'd2);
        chk("wait.err", error, 1'b0);
        chk("wait.b", operando_b, 16'h0002);
        press(4'hC);
        chk("wait.cancel.st", estado, 2'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
